axi4_full_slave_sram: RTL and testbench
=======================================

// Module: axi4_full_slave_sram
// PURPOSE
//  AXI4 full slave backed by a single-port-write / async-read SRAM array; serves as simulation main memory for the core.
//  Independent read and write channel engines support FIXED/INCR/WRAP bursts of up to 256 beats.
//  The array is addressed by word, with the upper address bits ignored, so the 0x8000_0000 base aliases to word 0.
//  Array contents are preloadable by hierarchical backdoor as i_sram.ram[word][8*b +: 8].
// PARAMETERS
//  DW  128  data width in bits (power of 2, >=32); WSTRB width = DW/8
//  AW  14   word-address width; depth = 2**AW words
//  IW  8    AXI ID width
// PORTS
//  CLK          in   1      clock; all logic on rising edge
//  RSTn         in   1      asynchronous active-low reset
//  MEM_AWID     in   IW     write ID;      MEM_BID    out IW   echoes latched AWID
//  MEM_AWADDR   in   32     byte address;  MEM_AWLEN  in 8 beats-1;  MEM_AWSIZE in 3;  MEM_AWBURST in 2
//  MEM_AWVALID  in   1      ;              MEM_AWREADY out 1
//  MEM_WDATA    in   DW ;   MEM_WSTRB in DW/8 ;  MEM_WLAST in 1 ;  MEM_WVALID in 1 ;  MEM_WREADY out 1
//  MEM_BRESP    out  2 ;    MEM_BVALID out 1 ;   MEM_BREADY in 1
//  MEM_ARID     in   IW ;   MEM_RID out IW ;  MEM_ARADDR in 32 ;  MEM_ARLEN in 8 ;  MEM_ARSIZE in 3 ;  MEM_ARBURST in 2
//  MEM_ARVALID  in   1 ;    MEM_ARREADY out 1
//  MEM_RDATA    out  DW ;   MEM_RRESP out 2 ;  MEM_RLAST out 1 ;  MEM_RVALID out 1 ;  MEM_RREADY in 1
// BEHAVIOUR
//  Reset (RSTn=0, async): all READY/VALID/LAST outputs = 0; BID/RID = 0; FSMs go to IDLE. Array contents are not cleared.
//  READY flags are registered and rise one cycle after reset release.
//  Word index = addr[AW+log2(DW/8)-1 : log2(DW/8)]; higher bits ignored (wrap-around aliasing).
//  Beat address update:
//    FIXED (00): unchanged.
//    INCR (01), and reserved 11 treated as INCR: addr += 1<<SIZE.
//    WRAP (10): addr += 1<<SIZE, wrapping inside an aligned window of (LEN+1)<<SIZE bytes.
//  Narrow beats (SIZE < log2(DW/8)) address the containing word.
//  Write FSM states: W_IDLE, W_DATA, W_RESP.
//    W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch ID/ADDR/LEN/SIZE/BURST, clear beat count, go to W_DATA.
//    W_DATA: AWREADY=0, WREADY=1. Each WVALID&WREADY writes every byte lane whose WSTRB bit is set, then advances addr/count.
//      The beat with count==LEN goes to W_RESP. WLAST is not used for termination.
//    W_RESP: WREADY=0, BVALID=1, BRESP=2'b00 (OKAY), BID=latched ID. On BREADY, go to W_IDLE (AWREADY=1 next cycle).
//  Read FSM states: R_IDLE, R_DATA.
//    R_IDLE: ARREADY=1. On ARVALID&ARREADY, latch ID/ADDR/LEN/SIZE/BURST, go to R_DATA.
//    R_DATA: RVALID=1 from the cycle after AR accept. RDATA = ram[word(cur addr)] (async read, full word).
//      RRESP=OKAY, RID=latched ID, RLAST=(count==LEN).
//      Each RVALID&RREADY advances addr/count; on the last beat, go to R_IDLE.
//      With RREADY=0, RDATA/RLAST are held (provided the location is not rewritten).
//  Read and write engines run concurrently with no arbitration.
//  Write and read to the same word in the same cycle: RDATA shows the old data that cycle and the new data next cycle.
//  Reset mid-burst aborts both engines. Beats already written remain in the array.
//  Throughput: 1 beat/cycle on W and R. The slave never inserts wait states inside a burst.
// STRUCTURE
//  Shared package: AXI burst encodings (FIXED/INCR/WRAP), RESP_OKAY, FSM state enums, next-address function.
//  Sub-module sram_array (instance name i_sram):
//    reg [DW-1:0] ram[0:2**AW-1]; byte-enable synchronous write port; asynchronous read port.
//    The array name 'ram' is fixed for backdoor load.
// TESTING
//  1. Backdoor ram[0]=128'h00112233_44556677_8899AABB_CCDDEEFF; AR addr 0x8000_0000, LEN 0, SIZE 4
//     -> one beat, RDATA equals that value, RLAST=1, RRESP=0.
//  2. AW 0x8000_0010, LEN 0, SIZE 4; W data 128'hA5.., WSTRB 16'h00FF; BREADY=1
//     -> BVALID one cycle after the W beat, BID=AWID; readback shows the low 8 bytes updated, the upper 8 bytes unchanged.
//  3. INCR AW 0x8000_0100, LEN 3, SIZE 4, data 1..4
//     -> ram[16..19]=1..4; INCR read LEN 3 returns 1,2,3,4 with RLAST only on beat 4.
//  4. WRAP read ARADDR 0x8000_0120, LEN 3, SIZE 4
//     -> beats from words 18,19,16,17.
//  5. Hold RREADY=0 for 5 cycles mid-burst
//     -> RVALID stays 1 and RDATA is stable; no beat is skipped once RREADY=1.
//  6. Assert RSTn=0 mid write burst
//     -> all VALID/READY=0 immediately; after release AWREADY=1 and a new transaction completes normally.

Source files
------------

// File: rtl/axi4_full_slave_sram_pkg.sv
// Shared definitions for the AXI4 SRAM slave: burst encodings, response codes,
// engine state enums and the per-beat address update.
package axi4_full_slave_sram_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_t;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}          r_state_t;

   // Address of the following beat. The reserved encoding behaves as INCR;
   // WRAP stays inside the aligned (len+1)<<size byte window.
   function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                             input logic [2:0]  size,
                                             input logic [7:0]  len,
                                             input burst_t      burst);
      logic [31:0] step;
      logic [31:0] sum;
      logic [31:0] mask;
      logic [31:0] res;
      step = 32'd1 << size;
      sum  = addr + step;
      mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
      case (burst)
         BURST_FIXED: res = addr;
         BURST_WRAP:  res = (addr & ~mask) | (sum & mask);
         default:     res = sum;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/sram_array.sv
// Word-addressed SRAM with a byte-enable synchronous write port and an
// asynchronous full-word read port. The array name 'ram' is relied on for backdoor loads.
module sram_array #(
   parameter int DW = 128,
   parameter int AW = 14
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [DW-1:0]   wdata,
   input  logic [DW/8-1:0] wstrb,
   input  logic [AW-1:0]   raddr,
   output logic [DW-1:0]   rdata
);

   logic [DW-1:0] ram [0:2**AW-1];

   // NOTE: the storage array has no reset branch; clearing it would turn the
   // RAM into a huge flop bank, and preloaded contents must survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DW/8; b++) begin
            if (wstrb[b]) ram[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = ram[raddr];

endmodule

// File: rtl/axi4_full_slave_sram.sv
// AXI4 full slave over a single SRAM: independent write (AW/W/B) and read (AR/R)
// engines with FIXED/INCR/WRAP bursts up to 256 beats, one beat per cycle.
module axi4_full_slave_sram
   import axi4_full_slave_sram_pkg::*;
#(
   parameter int DW = 128,
   parameter int AW = 14,
   parameter int IW = 8
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic [IW-1:0]   MEM_AWID,
   input  logic [31:0]     MEM_AWADDR,
   input  logic [7:0]      MEM_AWLEN,
   input  logic [2:0]      MEM_AWSIZE,
   input  logic [1:0]      MEM_AWBURST,
   input  logic            MEM_AWVALID,
   output logic            MEM_AWREADY,
   input  logic [DW-1:0]   MEM_WDATA,
   input  logic [DW/8-1:0] MEM_WSTRB,
   input  logic            MEM_WLAST,
   input  logic            MEM_WVALID,
   output logic            MEM_WREADY,
   output logic [IW-1:0]   MEM_BID,
   output logic [1:0]      MEM_BRESP,
   output logic            MEM_BVALID,
   input  logic            MEM_BREADY,
   input  logic [IW-1:0]   MEM_ARID,
   input  logic [31:0]     MEM_ARADDR,
   input  logic [7:0]      MEM_ARLEN,
   input  logic [2:0]      MEM_ARSIZE,
   input  logic [1:0]      MEM_ARBURST,
   input  logic            MEM_ARVALID,
   output logic            MEM_ARREADY,
   output logic [IW-1:0]   MEM_RID,
   output logic [DW-1:0]   MEM_RDATA,
   output logic [1:0]      MEM_RRESP,
   output logic            MEM_RLAST,
   output logic            MEM_RVALID,
   input  logic            MEM_RREADY
);

   localparam int OFFS = $clog2(DW/8);

   w_state_t    w_state;
   logic [31:0] w_addr;
   logic [7:0]  w_len, w_cnt;
   logic [2:0]  w_size;
   burst_t      w_burst;

   r_state_t    r_state;
   logic [31:0] r_addr;
   logic [7:0]  r_len, r_cnt;
   logic [2:0]  r_size;
   burst_t      r_burst;

   logic w_en;
   logic unused_ok;

   assign w_en      = MEM_WREADY & MEM_WVALID;
   assign MEM_BRESP = RESP_OKAY;
   assign MEM_RRESP = RESP_OKAY;
   assign MEM_RLAST = MEM_RVALID & (r_cnt == r_len);
   // Burst length alone ends a write; upper/lower address bits alias away.
   assign unused_ok = ^{MEM_WLAST, w_addr[31:AW+OFFS], w_addr[OFFS-1:0],
                        r_addr[31:AW+OFFS], r_addr[OFFS-1:0]};

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         w_state     <= W_IDLE;
         MEM_AWREADY <= 1'b0;
         MEM_WREADY  <= 1'b0;
         MEM_BVALID  <= 1'b0;
         MEM_BID     <= '0;
         w_addr      <= '0;
         w_len       <= '0;
         w_cnt       <= '0;
         w_size      <= '0;
         w_burst     <= BURST_FIXED;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (MEM_AWREADY && MEM_AWVALID) begin
                  MEM_BID     <= MEM_AWID;
                  w_addr      <= MEM_AWADDR;
                  w_len       <= MEM_AWLEN;
                  w_size      <= MEM_AWSIZE;
                  w_burst     <= burst_t'(MEM_AWBURST);
                  w_cnt       <= '0;
                  MEM_AWREADY <= 1'b0;
                  MEM_WREADY  <= 1'b1;
                  w_state     <= W_DATA;
               end else begin
                  MEM_AWREADY <= 1'b1;
               end
            end
            W_DATA: begin
               if (MEM_WVALID) begin
                  w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
                  w_cnt  <= w_cnt + 8'd1;
                  if (w_cnt == w_len) begin
                     MEM_WREADY <= 1'b0;
                     MEM_BVALID <= 1'b1;
                     w_state    <= W_RESP;
                  end
               end
            end
            default: begin
               if (MEM_BREADY) begin
                  MEM_BVALID  <= 1'b0;
                  MEM_AWREADY <= 1'b1;
                  w_state     <= W_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state     <= R_IDLE;
         MEM_ARREADY <= 1'b0;
         MEM_RVALID  <= 1'b0;
         MEM_RID     <= '0;
         r_addr      <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_size      <= '0;
         r_burst     <= BURST_FIXED;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (MEM_ARREADY && MEM_ARVALID) begin
                  MEM_RID     <= MEM_ARID;
                  r_addr      <= MEM_ARADDR;
                  r_len       <= MEM_ARLEN;
                  r_size      <= MEM_ARSIZE;
                  r_burst     <= burst_t'(MEM_ARBURST);
                  r_cnt       <= '0;
                  MEM_ARREADY <= 1'b0;
                  MEM_RVALID  <= 1'b1;
                  r_state     <= R_DATA;
               end else begin
                  MEM_ARREADY <= 1'b1;
               end
            end
            default: begin
               if (MEM_RREADY) begin
                  r_addr <= next_addr(r_addr, r_size, r_len, r_burst);
                  r_cnt  <= r_cnt + 8'd1;
                  if (r_cnt == r_len) begin
                     MEM_RVALID  <= 1'b0;
                     MEM_ARREADY <= 1'b1;
                     r_state     <= R_IDLE;
                  end
               end
            end
         endcase
      end
   end

   sram_array #(.DW(DW), .AW(AW)) i_sram (
      .clk   (CLK),
      .we    (w_en),
      .waddr (w_addr[AW+OFFS-1:OFFS]),
      .wdata (MEM_WDATA),
      .wstrb (MEM_WSTRB),
      .raddr (r_addr[AW+OFFS-1:OFFS]),
      .rdata (MEM_RDATA)
   );

endmodule

// File: tb/tb_axi4_full_slave_sram.sv
// Directed bench for axi4_full_slave_sram: backdoor read, strobed write, INCR/WRAP/FIXED
// bursts, read back-pressure and reset in the middle of a write burst.
module tb_axi4_full_slave_sram;

   localparam int DW  = 128;
   localparam int AW  = 14;
   localparam int IW  = 8;
   localparam int LIM = 50;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [IW-1:0]   awid = '0, arid = '0, bid, rid;
   logic [31:0]     awaddr = '0, araddr = '0;
   logic [7:0]      awlen = '0, arlen = '0;
   logic [2:0]      awsize = '0, arsize = '0;
   logic [1:0]      awburst = '0, arburst = '0, bresp, rresp;
   logic            awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
   logic            bvalid, bready = 1'b1, arvalid = 1'b0, arready;
   logic            rlast, rvalid, rready = 1'b0;
   logic [DW-1:0]   wdata = '0, rdata;
   logic [DW/8-1:0] wstrb = '0;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [127:0] rd_d;
   logic         rd_l;

   always #5 clk = ~clk;

   axi4_full_slave_sram #(.DW(DW), .AW(AW), .IW(IW)) dut (
      .CLK(clk), .RSTn(rst_n),
      .MEM_AWID(awid), .MEM_AWADDR(awaddr), .MEM_AWLEN(awlen), .MEM_AWSIZE(awsize),
      .MEM_AWBURST(awburst), .MEM_AWVALID(awvalid), .MEM_AWREADY(awready),
      .MEM_WDATA(wdata), .MEM_WSTRB(wstrb), .MEM_WLAST(wlast), .MEM_WVALID(wvalid),
      .MEM_WREADY(wready),
      .MEM_BID(bid), .MEM_BRESP(bresp), .MEM_BVALID(bvalid), .MEM_BREADY(bready),
      .MEM_ARID(arid), .MEM_RID(rid), .MEM_ARADDR(araddr), .MEM_ARLEN(arlen),
      .MEM_ARSIZE(arsize), .MEM_ARBURST(arburst), .MEM_ARVALID(arvalid),
      .MEM_ARREADY(arready),
      .MEM_RDATA(rdata), .MEM_RRESP(rresp), .MEM_RLAST(rlast), .MEM_RVALID(rvalid),
      .MEM_RREADY(rready)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ar_issue(input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input logic [7:0] id);
      int t = 0;
      araddr = a; arlen = len; arsize = 3'd4; arburst = burst; arid = id; arvalid = 1'b1;
      while (!arready && t < LIM) begin tick(); t++; end
      check("ar_ready_wait", 128'(t < LIM), 128'd1);
      tick();
      arvalid = 1'b0;
   endtask

   task automatic read_beat(output logic [127:0] d, output logic l);
      int t = 0;
      rready = 1'b1;
      while (!rvalid && t < LIM) begin tick(); t++; end
      check("r_valid_wait", 128'(t < LIM), 128'd1);
      check("r_resp", 128'(rresp), 128'd0);
      d = rdata;
      l = rlast;
      tick();
      rready = 1'b0;
   endtask

   task automatic aw_issue(input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input logic [7:0] id);
      int t = 0;
      awaddr = a; awlen = len; awsize = 3'd4; awburst = burst; awid = id; awvalid = 1'b1;
      while (!awready && t < LIM) begin tick(); t++; end
      check("aw_ready_wait", 128'(t < LIM), 128'd1);
      tick();
      awvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [127:0] d, input logic [15:0] s, input logic l);
      int t = 0;
      wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
      while (!wready && t < LIM) begin tick(); t++; end
      check("w_ready_wait", 128'(t < LIM), 128'd1);
      tick();
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   task automatic b_take(input logic [7:0] id);
      check("b_valid_after_last_w", 128'(bvalid), 128'd1);
      check("b_id", 128'(bid), 128'(id));
      check("b_resp", 128'(bresp), 128'd0);
      tick();
      check("b_done_aw_ready", 128'({bvalid, awready}), 128'b01);
   endtask

   initial begin
      // Reset state, then READY rises one cycle after release.
      tick(); tick();
      check("rst_ready_valid", 128'({awready, wready, bvalid, arready, rvalid, rlast}), 128'd0);
      check("rst_ids", 128'({bid, rid}), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready_low_right_after_release", 128'({awready, arready}), 128'b00);
      tick();
      check("ready_high_one_cycle_later", 128'({awready, arready}), 128'b11);

      // 1: backdoor load, single-beat read at the aliased base.
      dut.i_sram.ram[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      ar_issue(32'h8000_0000, 8'd0, 2'b01, 8'h3C);
      check("t1_rid", 128'(rid), 128'h3C);
      read_beat(rd_d, rd_l);
      check("t1_rdata", rd_d, 128'h00112233_44556677_8899AABB_CCDDEEFF);
      check("t1_rlast", 128'(rd_l), 128'd1);
      check("t1_rvalid_drops", 128'(rvalid), 128'd0);

      // 2: strobed single-beat write, upper half of the word untouched.
      dut.i_sram.ram[1] = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
      aw_issue(32'h8000_0010, 8'd0, 2'b01, 8'h5A);
      w_beat({16{8'hA5}}, 16'h00FF, 1'b1);
      b_take(8'h5A);
      ar_issue(32'h8000_0010, 8'd0, 2'b01, 8'h01);
      read_beat(rd_d, rd_l);
      check("t2_readback", rd_d, 128'hFFEEDDCC_BBAA9988_A5A5A5A5_A5A5A5A5);

      // 3: INCR write of 1..4 to words 16..19, then INCR read back.
      aw_issue(32'h8000_0100, 8'd3, 2'b01, 8'h77);
      for (int b = 0; b < 4; b++) w_beat(128'(b + 1), 16'hFFFF, b == 3);
      b_take(8'h77);
      for (int b = 0; b < 4; b++) check("t3_backdoor", dut.i_sram.ram[16 + b], 128'(b + 1));
      ar_issue(32'h8000_0100, 8'd3, 2'b01, 8'h02);
      for (int b = 0; b < 4; b++) begin
         read_beat(rd_d, rd_l);
         check("t3_rdata", rd_d, 128'(b + 1));
         check("t3_rlast", 128'(rd_l), 128'(b == 3));
      end

      // 4: WRAP read from word 18 visits 18,19,16,17.
      ar_issue(32'h8000_0120, 8'd3, 2'b10, 8'h04);
      read_beat(rd_d, rd_l); check("t4_beat0", rd_d, 128'd3);
      read_beat(rd_d, rd_l); check("t4_beat1", rd_d, 128'd4);
      read_beat(rd_d, rd_l); check("t4_beat2", rd_d, 128'd1);
      read_beat(rd_d, rd_l); check("t4_beat3", rd_d, 128'd2);
      check("t4_rlast_final", 128'(rd_l), 128'd1);

      // 5: back-pressure for 5 cycles in the middle of an INCR burst.
      ar_issue(32'h8000_0100, 8'd3, 2'b01, 8'h05);
      read_beat(rd_d, rd_l); check("t5_beat0", rd_d, 128'd1);
      read_beat(rd_d, rd_l); check("t5_beat1", rd_d, 128'd2);
      for (int c = 0; c < 5; c++) begin
         check("t5_hold_valid_last", 128'({rvalid, rlast}), 128'b10);
         check("t5_hold_data", rdata, 128'd3);
         tick();
      end
      read_beat(rd_d, rd_l); check("t5_beat2", rd_d, 128'd3);
      read_beat(rd_d, rd_l); check("t5_beat3", rd_d, 128'd4);
      check("t5_last", 128'(rd_l), 128'd1);
      check("t5_no_extra_beat", 128'(rvalid), 128'd0);

      // FIXED burst keeps writing the same word.
      dut.i_sram.ram[20] = 128'd0;
      dut.i_sram.ram[21] = 128'h77;
      aw_issue(32'h8000_0140, 8'd1, 2'b00, 8'h06);
      w_beat(128'h11, 16'hFFFF, 1'b0);
      w_beat(128'h22, 16'hFFFF, 1'b1);
      b_take(8'h06);
      check("fixed_word20", dut.i_sram.ram[20], 128'h22);
      check("fixed_word21", dut.i_sram.ram[21], 128'h77);

      // 6: reset in the middle of a 4-beat write.
      aw_issue(32'h8000_0200, 8'd3, 2'b01, 8'h09);
      w_beat({16{8'hAA}}, 16'hFFFF, 1'b0);
      w_beat({16{8'hBB}}, 16'hFFFF, 1'b0);
      rst_n = 1'b0;
      #1;
      check("t6_async_clear", 128'({awready, wready, bvalid, arready, rvalid}), 128'd0);
      check("t6_word32_kept", dut.i_sram.ram[32], {16{8'hAA}});
      check("t6_word33_kept", dut.i_sram.ram[33], {16{8'hBB}});
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("t6_aw_ready_after_release", 128'(awready), 128'd1);
      aw_issue(32'h8000_0300, 8'd0, 2'b01, 8'h0A);
      w_beat(128'hCAFE, 16'hFFFF, 1'b1);
      b_take(8'h0A);
      ar_issue(32'h8000_0300, 8'd0, 2'b01, 8'h0B);
      check("t6_rid", 128'(rid), 128'h0B);
      read_beat(rd_d, rd_l);
      check("t6_readback", rd_d, 128'hCAFE);
      check("t6_rlast", 128'(rd_l), 128'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
